tdm_demux116: RTL and testbench
===============================

// Module: tdm_demux116
// PURPOSE
//   Registered 1:16 demultiplexer. It is the receive-side counterpart of the 16:1 mux
//   (alt_mux161): it routes a 1-bit stream into 16 lane registers.
//   - Lane choice is either an explicit select (addressed mode) or an internal
//     wrap-around counter (sequential/TDM mode).
//   - Once every lane has been written, the block publishes a 16-bit frame.
//   - The frame is handed off with a valid/ack handshake.
// PARAMETERS
//   N_LANES  16  number of output lanes; fixed at 16 in this revision
//   SEL_W    4   select/counter width; must equal clog2(N_LANES)
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   din          in   1        serial data bit
//   din_valid    in   1        din is written this cycle
//   mode         in   1        0 = addressed (use s), 1 = sequential (use internal counter)
//   s            in   SEL_W    lane select in addressed mode; ignored in sequential mode
//   frame_start  in   1        synchronous resync: clears lane flags, counter := 0
//   frame_ack    in   1        consumer accepts frame_data
//   o            out  N_LANES  live lane registers
//   lane_vld     out  N_LANES  per-lane "written in current frame" flags
//   sel_cur      out  SEL_W    internal counter value (next lane in sequential mode)
//   frame_data   out  N_LANES  last completed frame
//   frame_valid  out  1        frame_data is held, awaiting ack
//   lane_ovr     out  1        sticky: a lane was rewritten before its frame completed
//   frame_ovr    out  1        sticky: a frame completed while the previous one was unacked
//   clr_ovr      in   1        synchronous clear of both overflow flags
// BEHAVIOUR
//   Reset
//   - All outputs go to 0: o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr.
//   - Reset is asynchronous and may assert mid-frame; partial lane data is discarded.
//   Write
//   - Target lane: L = mode ? sel_cur : s.
//   - On a clk edge with din_valid=1: o[L] <= din and lane_vld[L] <= 1.
//   - Latency: o and lane_vld reflect the write 1 cycle after din_valid.
//   - Sequential mode: every write does sel_cur <= sel_cur+1, wrapping 15 -> 0.
//   - Addressed mode: sel_cur holds its value.
//   - mode is sampled per write; switching mode never clears lane_vld.
//   Lane overflow
//   - A write to a lane with lane_vld[L]=1 sets lane_ovr.
//   - The write still completes and overwrites o[L].
//   Frame completion
//   - Condition C: a write leaves (lane_vld | onehot(L)) == 16'hFFFF.
//   - On the C edge: frame_data <= {o with o[L] replaced by din}, lane_vld <= 0, frame_valid <= 1.
//   - frame_valid therefore rises 1 cycle after the completing din_valid.
//   Frame handshake
//   - frame_valid stays 1 and frame_data stays stable until frame_ack=1 while frame_valid=1.
//   - On that ack, frame_valid <= 0 the next cycle, unless C occurs in the same cycle.
//   - C together with ack: the new frame loads, frame_valid stays 1, no overflow.
//   - C with frame_valid=1 and no ack: frame_data is overwritten, frame_ovr <= 1, frame_valid stays 1.
//   - frame_ack while frame_valid=0 has no effect.
//   frame_start
//   - Effect: lane_vld <= 0 and sel_cur <= 0.
//   - o, frame_data and frame_valid are not affected.
//   - With din_valid in the same cycle, frame_start takes priority and the write still happens.
//   - That write targets lane 0 in sequential mode (or s in addressed mode).
//   - Resulting state: lane_vld = onehot(lane), sel_cur = 1 in sequential mode.
//   clr_ovr
//   - Clears both overflow flags.
//   - A new overflow in the same cycle wins (flag ends at 1).
//   Logic style
//   - No combinational path from any input to any output; all outputs are registered.
// STRUCTURE
//   - Package demux_pkg holds: N_LANES, SEL_W, MODE_ADDR=1'b0, MODE_SEQ=1'b1, FULL_MASK=16'hFFFF.
//   - Sub-module dec_4to16 is the combinational select -> one-hot decoder.
//     It drives the write enables and the completion test.
//   - The top level holds the lane, flag, counter and frame registers and the handshake logic.
// TESTING
//   1. Sequential mode: 16 writes of din=1,0,1,0,... ->
//      frame_valid=1 one cycle after write 16, frame_data=16'h5555, lane_vld=0, sel_cur=0.
//   2. Addressed mode: s=15..0 descending, din=1 only at s=3 ->
//      frame_data=16'h0008, lane_ovr=0.
//   3. Addressed mode: write s=5 twice, then fill the remaining lanes ->
//      lane_ovr=1 after the second write, frame completes after the 16th distinct lane.
//   4. Complete frame A, hold frame_ack=0, complete frame B ->
//      frame_ovr=1, frame_data=B, frame_valid=1.
//      Repeat with ack on B's completion cycle -> frame_ovr stays 0.
//   5. After 7 sequential writes, frame_start together with din_valid ->
//      lane_vld=16'h0001, sel_cur=1; 15 further writes are needed to complete the frame.
//   6. Assert rst mid-frame (asynchronously, between edges) ->
//      all outputs are 0 immediately; after release, a full 16-write frame completes normally.

Source files
------------

// File: rtl/tdm_demux116_pkg.sv
// Shared constants for the 1:16 TDM demultiplexer.
package demux_pkg;
  localparam int unsigned N_LANES = 16;
  localparam int unsigned SEL_W = 4;
  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_SEQ = 1'b1;
  localparam logic [N_LANES-1:0] FULL_MASK = 16'hFFFF;
endpackage

// File: rtl/tdm_demux116_dec_4to16.sv
// Select to one-hot decoder; all-zero output when not enabled.
module dec_4to16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [N_LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    onehot[sel] = en;
  end

endmodule

// File: rtl/tdm_demux116.sv
// Registered 1:16 demux: lane registers, per-frame lane flags, TDM counter and
// a valid/ack frame hand-off with sticky overflow flags.
module tdm_demux116
  import demux_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               mode,
  input  logic [SEL_W-1:0]   s,
  input  logic               frame_start,
  input  logic               frame_ack,
  input  logic               clr_ovr,
  output logic [N_LANES-1:0] o,
  output logic [N_LANES-1:0] lane_vld,
  output logic [SEL_W-1:0]   sel_cur,
  output logic [N_LANES-1:0] frame_data,
  output logic               frame_valid,
  output logic               lane_ovr,
  output logic               frame_ovr
);

  logic [SEL_W-1:0]   sel_base, lane_sel, sel_cur_d;
  logic [N_LANES-1:0] vld_base, wr_oh, o_d, lane_vld_d, frame_data_d;
  logic               complete, frame_valid_d, lane_ovr_d, frame_ovr_d;

  // frame_start clears flags and counter before this cycle's write is applied
  assign sel_base = frame_start ? '0 : sel_cur;
  assign vld_base = frame_start ? '0 : lane_vld;
  assign lane_sel = (mode == MODE_ADDR) ? s : sel_base;

  dec_4to16 u_dec (
    .sel    (lane_sel),
    .en     (din_valid),
    .onehot (wr_oh)
  );

  assign complete = din_valid && ((vld_base | wr_oh) == FULL_MASK);

  always_comb begin
    o_d           = (o & ~wr_oh) | (wr_oh & {N_LANES{din}});
    lane_vld_d    = complete ? '0 : (vld_base | wr_oh);
    sel_cur_d     = (din_valid && mode == MODE_SEQ) ? sel_base + SEL_W'(1) : sel_base;
    frame_data_d  = complete ? o_d : frame_data;
    frame_valid_d = frame_valid;
    if (complete) begin
      frame_valid_d = 1'b1;
    end else if (frame_ack) begin
      frame_valid_d = 1'b0;
    end
    lane_ovr_d  = lane_ovr;
    frame_ovr_d = frame_ovr;
    if (clr_ovr) begin
      lane_ovr_d  = 1'b0;
      frame_ovr_d = 1'b0;
    end
    // a fresh overflow in the same cycle as clr_ovr wins
    if ((vld_base & wr_oh) != '0) lane_ovr_d = 1'b1;
    if (complete && frame_valid && !frame_ack) frame_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o           <= '0;
      lane_vld    <= '0;
      sel_cur     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      lane_ovr    <= 1'b0;
      frame_ovr   <= 1'b0;
    end else begin
      o           <= o_d;
      lane_vld    <= lane_vld_d;
      sel_cur     <= sel_cur_d;
      frame_data  <= frame_data_d;
      frame_valid <= frame_valid_d;
      lane_ovr    <= lane_ovr_d;
      frame_ovr   <= frame_ovr_d;
    end
  end

endmodule

// File: tb/tb_tdm_demux116.sv
// Self-checking bench for tdm_demux116 against a lane/frame reference model.
module tb_tdm_demux116;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0, din_valid = 1'b0, mode = 1'b0;
  logic [3:0]  s = '0;
  logic        frame_start = 1'b0, frame_ack = 1'b0, clr_ovr = 1'b0;
  logic [15:0] o, lane_vld, frame_data;
  logic [3:0]  sel_cur;
  logic        frame_valid, lane_ovr, frame_ovr;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit [15:0] m_o, m_vld, m_fd;
  int        m_sel;
  bit        m_fv, m_lovr, m_fovr;

  tdm_demux116 dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .mode        (mode),
    .s           (s),
    .frame_start (frame_start),
    .frame_ack   (frame_ack),
    .clr_ovr     (clr_ovr),
    .o           (o),
    .lane_vld    (lane_vld),
    .sel_cur     (sel_cur),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .lane_ovr    (lane_ovr),
    .frame_ovr   (frame_ovr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_o = '0; m_vld = '0; m_fd = '0; m_sel = 0;
    m_fv = 0; m_lovr = 0; m_fovr = 0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later.
  task automatic step(input bit dv, input bit d, input bit md, input int sv,
                      input bit fs, input bit ak, input bit co);
    int lane;
    bit done, lset, fset;
    din_valid = dv; din = d; mode = md; s = 4'(sv);
    frame_start = fs; frame_ack = ak; clr_ovr = co;
    @(posedge clk);
    done = 0; lset = 0; fset = 0;
    if (fs) begin
      m_vld = '0;
      m_sel = 0;
    end
    lane = md ? m_sel : sv;
    if (dv) begin
      if (m_vld[lane]) lset = 1;
      m_o[lane] = d;
      m_vld[lane] = 1;
      if (md) m_sel = (m_sel + 1) % 16;
      if ($countones(m_vld) == 16) done = 1;
    end
    if (done) begin
      if (m_fv && !ak) fset = 1;
      m_fd = m_o;
      m_fv = 1;
      m_vld = '0;
    end else if (ak && m_fv) begin
      m_fv = 0;
    end
    if (co) begin
      m_lovr = 0;
      m_fovr = 0;
    end
    if (lset) m_lovr = 1;
    if (fset) m_fovr = 1;
    #1;
  endtask

  task automatic idle_ack_clr();
    step(0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #2;
    tests++;
    if ({o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr} !== '0) begin
      fails++;
      $display("FAIL reset_state: got o=%h vld=%h sel=%h fd=%h fv=%b lo=%b fo=%b, want all 0",
               o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_seq_frame();
    for (int i = 0; i < 16; i++) begin
      step(1, (i % 2) == 0, 1, 0, 0, 0, 0);
      if (i == 14) begin
        tests++;
        if (frame_valid !== 1'b0) begin
          fails++;
          $display("FAIL seq_early_valid: frame_valid=%b want 0", frame_valid);
        end
      end
    end
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== 16'h5555 || lane_vld !== 16'h0 ||
        sel_cur !== 4'd0) begin
      fails++;
      $display("FAIL seq_frame: fv=%b fd=%h vld=%h sel=%0d want 1 5555 0000 0",
               frame_valid, frame_data, lane_vld, sel_cur);
    end
  endtask

  task automatic test_addr_frame();
    idle_ack_clr();
    for (int sv = 15; sv >= 0; sv--) begin
      step(1, sv == 3, 0, sv, 0, 0, 0);
      if (sv == 8) begin
        tests++;
        if (lane_vld !== 16'hFF00 || sel_cur !== 4'd0) begin
          fails++;
          $display("FAIL addr_partial: vld=%h sel=%0d want ff00 0", lane_vld, sel_cur);
        end
      end
    end
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== 16'h0008 || lane_ovr !== 1'b0) begin
      fails++;
      $display("FAIL addr_frame: fv=%b fd=%h lo=%b want 1 0008 0",
               frame_valid, frame_data, lane_ovr);
    end
  endtask

  task automatic test_lane_ovr();
    idle_ack_clr();
    step(1, 1, 0, 5, 0, 0, 0);
    step(1, 0, 0, 5, 0, 0, 0);
    tests++;
    if (lane_ovr !== 1'b1 || o[5] !== 1'b0) begin
      fails++;
      $display("FAIL lane_ovr_set: lo=%b o5=%b want 1 0", lane_ovr, o[5]);
    end
    for (int sv = 0; sv < 16; sv++) begin
      if (sv == 5) continue;
      step(1, 1'($urandom), 0, sv, 0, 0, 0);
      if (sv == 14) begin
        tests++;
        if (frame_valid !== 1'b0) begin
          fails++;
          $display("FAIL lane_ovr_early: fv=%b want 0", frame_valid);
        end
      end
    end
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== m_fd || lane_ovr !== 1'b1) begin
      fails++;
      $display("FAIL lane_ovr_frame: fv=%b fd=%h lo=%b want 1 %h 1",
               frame_valid, frame_data, lane_ovr, m_fd);
    end
  endtask

  task automatic test_frame_ovr();
    bit [15:0] fb;
    idle_ack_clr();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) step(1, 1'($urandom), 1, 0, 0, 0, 0);
    fb = m_fd;
    tests++;
    if (frame_ovr !== 1'b1 || frame_valid !== 1'b1 || frame_data !== fb) begin
      fails++;
      $display("FAIL frame_ovr_set: fo=%b fv=%b fd=%h want 1 1 %h",
               frame_ovr, frame_valid, frame_data, fb);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 1'($urandom), 1, 0, 0, i == 15, 0);
    tests++;
    if (frame_ovr !== 1'b0 || frame_valid !== 1'b1 || frame_data !== m_fd) begin
      fails++;
      $display("FAIL frame_ack_same_cycle: fo=%b fv=%b fd=%h want 0 1 %h",
               frame_ovr, frame_valid, frame_data, m_fd);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    tests++;
    if (frame_valid !== 1'b0 || frame_data !== m_fd) begin
      fails++;
      $display("FAIL frame_ack_release: fv=%b fd=%h want 0 %h", frame_valid, frame_data, m_fd);
    end
  endtask

  task automatic test_frame_start();
    idle_ack_clr();
    for (int i = 0; i < 7; i++) step(1, 1'($urandom), 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0);
    tests++;
    if (lane_vld !== 16'h0001 || sel_cur !== 4'd1 || lane_ovr !== 1'b0) begin
      fails++;
      $display("FAIL frame_start: vld=%h sel=%0d lo=%b want 0001 1 0", lane_vld, sel_cur, lane_ovr);
    end
    for (int i = 0; i < 15; i++) begin
      step(1, 1'($urandom), 1, 0, 0, 0, 0);
      if (i == 13) begin
        tests++;
        if (frame_valid !== 1'b0) begin
          fails++;
          $display("FAIL frame_start_early: fv=%b want 0", frame_valid);
        end
      end
    end
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== m_fd) begin
      fails++;
      $display("FAIL frame_start_done: fv=%b fd=%h want 1 %h", frame_valid, frame_data, m_fd);
    end
  endtask

  task automatic test_rst_mid();
    idle_ack_clr();
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr} !== '0) begin
      fails++;
      $display("FAIL rst_mid: o=%h vld=%h sel=%h fd=%h fv=%b lo=%b fo=%b want all 0",
               o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step(1, 1'($urandom), 1, 0, 0, 0, 0);
    tests++;
    if (frame_valid !== 1'b1 || frame_data !== m_fd || frame_ovr !== 1'b0) begin
      fails++;
      $display("FAIL rst_recover: fv=%b fd=%h fo=%b want 1 %h 0",
               frame_valid, frame_data, frame_ovr, m_fd);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 15),
           $urandom_range(0, 30) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 20) == 0);
      tests++;
      if ({o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr} !==
          {m_o, m_vld, 4'(m_sel), m_fd, m_fv, m_lovr, m_fovr}) begin
        fails++;
        if (errs++ < 10)
          $display("FAIL random[%0d]: o=%h vld=%h sel=%0d fd=%h fv=%b lo=%b fo=%b want %h %h %0d %h %b %b %b",
                   i, o, lane_vld, sel_cur, frame_data, frame_valid, lane_ovr, frame_ovr,
                   m_o, m_vld, m_sel, m_fd, m_fv, m_lovr, m_fovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_frame();
    test_addr_frame();
    test_lane_ovr();
    test_frame_ovr();
    test_frame_start();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
